// File: rtl/not_arbiter.sv
// Round-robin arbiter in front of a shared registered bitwise inverter.
// Accepted words come back inverted, tagged with the requester index, from a one-entry output register.
module not_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [IDW-1:0]         rsp_id,
    input  logic                   rsp_ready
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Handshake: a word moves when req_valid[i] && req_ready[i] at a rising edge;
    // a result moves when rsp_valid && rsp_ready at a rising edge.
    logic [0:0]       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;

    logic             slot_free;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand_idx;
    logic [WIDTH-1:0] word [N_REQ];

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            word[k] = req_data[k*WIDTH +: WIDTH];
        end
    end

    // Reset gates the slot so req_ready stays low while rst is held.
    assign slot_free = !rst && ((state_q == ST_EMPTY) || rsp_ready);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_idx = ptr_q + IDW'(k);
            if (({1'b0, ptr_q} + (IDW+1)'(k)) >= (IDW+1)'(N_REQ)) begin
                cand_idx = ptr_q + IDW'(k) - IDW'(N_REQ);
            end
            if (!grant_found && slot_free && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign req_ready = grant_found ? (N_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        if (grant_found) begin
            state_d    = ST_FULL;
            rsp_data_d = ~word[grant_idx];
            rsp_id_d   = grant_idx;
            ptr_d      = (grant_idx == IDW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            ptr_q      <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_not_arbiter.sv
// Directed bench for not_arbiter (N_REQ=4, WIDTH=8): vector table plus reset sequences.
module tb_not_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic [WIDTH-1:0]       rsp_data;
    logic [IDW-1:0]         rsp_id;
    logic                   rsp_ready;

    int checks;
    int errors;

    typedef struct {
        logic [N_REQ-1:0]       valid;
        logic [N_REQ*WIDTH-1:0] data;
        logic                   rready;
        logic [N_REQ-1:0]       exp_ready;
        logic                   exp_v;
        logic [WIDTH-1:0]       exp_d;
        logic [IDW-1:0]         exp_id;
    } vec_t;

    vec_t vec_q[$];

    not_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [3:0] v, input logic [31:0] d, input logic rr,
                           input logic [3:0] er, input logic ev, input logic [7:0] ed,
                           input logic [1:0] eid);
        vec_t t;
        t.valid = v; t.data = d; t.rready = rr;
        t.exp_ready = er; t.exp_v = ev; t.exp_d = ed; t.exp_id = eid;
        vec_q.push_back(t);
    endtask

    initial begin
        logic [7:0] rr_exp [4];
        checks = 0;
        errors = 0;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        rsp_ready = 1'b0;

        // round robin, all valid from reset: ids 0,1,2,3,0,1,2,3
        rr_exp[0] = 8'hEE; rr_exp[1] = 8'hDD; rr_exp[2] = 8'hCC; rr_exp[3] = 8'hBB;
        for (int k = 0; k < 8; k++) begin
            add_vec(4'hF, 32'h44332211, 1'b1, 4'(1 << (k % 4)), 1'b1, rr_exp[k % 4], 2'(k % 4));
        end
        add_vec(4'h0, 32'h0,        1'b1, 4'b0000, 1'b0, 8'hBB, 2'd3); // drain only
        add_vec(4'h4, 32'h553C1234, 1'b1, 4'b0100, 1'b1, 8'hC3, 2'd2); // single request
        add_vec(4'h1, 32'h11223300, 1'b1, 4'b0001, 1'b1, 8'hFF, 2'd0); // ptr 3 wraps to 0
        for (int k = 0; k < 3; k++) begin
            add_vec(4'hF, 32'h44332211, 1'b0, 4'b0000, 1'b1, 8'hFF, 2'd0); // backpressure
        end
        add_vec(4'hF, 32'h44332211, 1'b1, 4'b0010, 1'b1, 8'hDD, 2'd1); // drain+refill
        add_vec(4'h8, 32'h80000000, 1'b1, 4'b1000, 1'b1, 8'h7F, 2'd3); // last grant 3
        add_vec(4'hA, 32'h0F00F000, 1'b1, 4'b0010, 1'b1, 8'h0F, 2'd1); // skip to 1
        add_vec(4'hA, 32'h0F00F000, 1'b1, 4'b1000, 1'b1, 8'hF0, 2'd3); // then 3
        add_vec(4'h0, 32'h0,        1'b1, 4'b0000, 1'b0, 8'hF0, 2'd3); // drain
        add_vec(4'h0, 32'h0,        1'b1, 4'b0000, 1'b0, 8'hF0, 2'd3); // rsp_ready while empty
        add_vec(4'h1, 32'h0000005A, 1'b0, 4'b0001, 1'b1, 8'hA5, 2'd0); // accept while empty
        add_vec(4'h0, 32'h0,        1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0); // hold
        add_vec(4'h0, 32'h0,        1'b1, 4'b0000, 1'b0, 8'hA5, 2'd0); // drain

        // reset held with random inputs
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'($urandom_range(0, 15));
            req_data  = $urandom;
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            check("rst_ready", 32'(req_ready), 32'h0);
            check("rst_valid", 32'(rsp_valid), 32'h0);
            check("rst_data",  32'(rsp_data),  32'h0);
            check("rst_id",    32'(rsp_id),    32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        req_data = '0;
        rsp_ready = 1'b0;

        for (int i = 0; i < vec_q.size(); i++) begin
            @(negedge clk);
            req_valid = vec_q[i].valid;
            req_data  = vec_q[i].data;
            rsp_ready = vec_q[i].rready;
            #1;
            check($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vec_q[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vec_q[i].exp_v));
            check($sformatf("v%0d_rsp_data", i),  32'(rsp_data),  32'(vec_q[i].exp_d));
            check($sformatf("v%0d_rsp_id", i),    32'(rsp_id),    32'(vec_q[i].exp_id));
        end

        // asynchronous reset mid-cycle while FULL
        @(negedge clk);
        req_valid = 4'h1;
        req_data  = 32'h00000077;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        check("arst_pre_valid", 32'(rsp_valid), 32'h1);
        check("arst_pre_data",  32'(rsp_data),  32'h88);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(rsp_valid), 32'h0);
        check("arst_data",  32'(rsp_data),  32'h0);
        check("arst_id",    32'(rsp_id),    32'h0);
        check("arst_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'h44332211;
        rsp_ready = 1'b1;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(rsp_valid), 32'h1);
        check("post_rst_data",  32'(rsp_data),  32'hEE);
        check("post_rst_id",    32'(rsp_id),    32'h0);

        @(negedge clk);
        req_valid = '0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/not_arbiter.md
# not_arbiter

Shares one registered bitwise-inverter unit (out = ~in) among N_REQ requesters with round-robin fairness. Each requester offers a word on a valid/ready handshake. The arbiter grants at most one requester per cycle and returns the inverted word through a single-entry output register with the requester ID attached. It sits between the stimulus/requester blocks and the shared NOT datapath, and sequences all accesses to that datapath.

## Interface
- N_REQ, default 4: number of requesters; legal range 2..16.
- WIDTH, default 8: data width in bits; minimum 1.
- IDW, derived as $clog2(N_REQ): width of the requester ID.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  bit i: requester i offers a word.
- req_data  in  N_REQ*WIDTH  requester i's word in bits [i*WIDTH +: WIDTH].
- req_ready  out  N_REQ  one-hot or zero; bit i high means requester i is accepted this cycle.
- rsp_valid  out  1  output register holds a result.
- rsp_data  out  WIDTH  inverted word, equal to ~req_data slice of the granted requester.
- rsp_id  out  IDW  index of the requester that produced rsp_data.
- rsp_ready  in  1  consumer accepts the result.

## Operation
- Two states, tracked by rsp_valid:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- A slot is free when the block is EMPTY, or when it is FULL and rsp_ready=1 (drain and refill in the same cycle).
- Grant rule:
  - When a slot is free and any req_valid is high, grant the first requester with valid set, searching upward with wrap from index ptr.
  - req_ready is combinational and carries the grant only. Its value must not depend on rsp_ready except through the slot-free term.
- Handshake (accept) on grant g: at the next edge, rsp_data <= ~req_data[g], rsp_id <= g, rsp_valid <= 1, and ptr <= (g+1) mod N_REQ.
- Drain with no grant: FULL with rsp_ready=1 and no request goes to EMPTY. rsp_data and rsp_id hold their last values.
- Hold: FULL with rsp_ready=0 keeps rsp_valid, rsp_data and rsp_id stable, and req_ready stays all zero.
- ptr changes only on an accept. It wraps from N_REQ-1 to 0.
- Requesters may drop req_valid without being granted. The arbiter holds no memory of unaccepted requests.
- rsp_ready while EMPTY is ignored.
- Inversion covers the full WIDTH bits. No other arithmetic is performed.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, ptr=0, req_ready=0.
- Reset asserted mid-transfer clears state immediately, without waiting for a clock edge. An in-flight result is lost and is not replayed.
- Latency is 1 cycle: a word accepted at edge k appears on rsp_data in cycle k+1.
- Sustained throughput is 1 word per cycle when rsp_ready=1 continuously.
- Fairness: with all requesters continuously valid, each is granted exactly once in every N_REQ accepts.
- First cycle after rst deasserts: requester 0 has highest priority.
- Simultaneous drain and accept in one cycle: the new result replaces the old one. No bubble cycle and no duplicate result.

## Test plan
- Reset check: hold rst=1 with random inputs -> rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0. Assert rst asynchronously mid-cycle while FULL -> rsp_valid drops before the next edge.
- Single request, N_REQ=4, WIDTH=8: req_valid=4'b0100, slice 2=8'h3C, rsp_ready=1 -> req_ready=4'b0100, then one cycle later rsp_valid=1, rsp_data=8'hC3, rsp_id=2.
- Round-robin: all four valid for 8 cycles with rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1,2,3, one result per cycle.
- Backpressure: FULL with rsp_data=8'hFF and rsp_ready=0 for 3 cycles with requests pending -> outputs stable and req_ready=0. Then raise rsp_ready -> accept in the same cycle and the new result appears the next cycle.
- Pointer wrap and skip: last grant was id 3, and only req 1 and req 3 valid -> grant 1 next, then 3.
- Drain only: FULL, rsp_ready=1, no requests -> rsp_valid=0 next cycle; rsp_data and rsp_id unchanged.
